// File: rtl/gain_coeff_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gain_coeff_ctrl
// Purpose  : Automatic gain controller for the spectrum digital-gain stage.
//            Tracks the peak of a window of 2^WIN_LOG2 frames, finds its
//            leading one with a 32-cycle serial search, and derives a shift
//            coefficient that places the peak at output bit TARGET_MSB.
//            Attacks immediately, decays one step per window outside a
//            dead-band of HYST steps. New coefficients are applied only on
//            frame markers.
// Ports    : clk, rst_n            clock, async active-low reset
//            ms_in, max_in[31:0]   frame marker and previous frame peak
//            cfg_auto              1 = automatic, 0 = manual coefficient
//            cfg_manual_coeff[4:0] manual shift (clamped to 16)
//            scaled_coeff[15:0]    shift coefficient (0..16)
//            coeff_update          pulse when scaled_coeff changes
//            clip_det              pulse when window peak overflowed window
//            overrun               pulse when a window closes mid-search
// Revision : 1.0 - initial release
// ============================================================================
module gain_coeff_ctrl #(
    parameter int WIN_LOG2   = 2,
    parameter int TARGET_MSB = 14,
    parameter int HYST       = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ms_in,
    input  logic [31:0] max_in,
    input  logic        cfg_auto,
    input  logic [4:0]  cfg_manual_coeff,
    output logic [15:0] scaled_coeff,
    output logic        coeff_update,
    output logic        clip_det,
    output logic        overrun
);

    // Frame counter needs at least one bit even for single-frame windows.
    localparam int FCW = (WIN_LOG2 == 0) ? 1 : WIN_LOG2;
    localparam logic [FCW-1:0] c_win_last = FCW'((1 << WIN_LOG2) - 1);
    localparam logic [5:0]     c_target   = 6'(TARGET_MSB);
    localparam logic [5:0]     c_hyst     = 6'(HYST);
    localparam logic [4:0]     c_coeff_max = 5'd16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DECIDE = 2'd2,
        PEND   = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic [31:0]    r_peak;
    logic [FCW-1:0] r_frame_cnt;
    logic [31:0]    r_srch;
    logic [4:0]     r_bit_idx;
    logic           r_found;
    logic [4:0]     r_p;
    logic [4:0]     r_next;
    logic [4:0]     r_cur;
    logic           r_coeff_update;
    logic           r_clip;
    logic           r_overrun;

    logic [31:0]    w_combined;
    logic           w_win_close;
    logic [4:0]     w_man;
    logic [5:0]     w_p_ext;
    logic [5:0]     w_diff;
    logic [4:0]     w_want;
    logic [5:0]     w_decay_gap;
    logic [4:0]     w_next_coeff;
    logic           w_clip;

    assign w_combined  = (max_in > r_peak) ? max_in : r_peak;
    assign w_win_close = cfg_auto && ms_in && (r_frame_cnt == c_win_last);
    assign w_man       = (cfg_manual_coeff > c_coeff_max) ? c_coeff_max : cfg_manual_coeff;
    assign w_p_ext     = {1'b0, r_p};

    // Decision datapath: only meaningful while r_state == DECIDE.
    always_comb begin
        w_diff       = 6'd0;
        w_want       = 5'd0;
        w_decay_gap  = 6'd0;
        w_next_coeff = r_cur;
        w_clip       = 1'b0;

        if (r_found && (w_p_ext > c_target)) begin
            w_diff = w_p_ext - c_target;
            w_want = (w_diff > {1'b0, c_coeff_max}) ? c_coeff_max : w_diff[4:0];
        end

        if (w_want > r_cur) begin
            w_next_coeff = w_want;
        end else begin
            w_decay_gap = {1'b0, r_cur - w_want};
            if (w_decay_gap > c_hyst) begin
                w_next_coeff = r_cur - 5'd1;
            end
        end

        // Peak's leading one sits above the top of the current 16-bit window.
        w_clip = r_found && (w_p_ext > ({1'b0, r_cur} + 6'd15));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_win_close) begin
                    w_state_nxt = SEARCH;
                end
            end
            SEARCH: begin
                if (r_bit_idx == 5'd0) begin
                    w_state_nxt = DECIDE;
                end
            end
            DECIDE: begin
                w_state_nxt = (w_next_coeff != r_cur) ? PEND : IDLE;
            end
            PEND: begin
                if (ms_in) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (!cfg_auto) begin
            w_state_nxt = IDLE;
        end
    end

    // Accumulator, search and coefficient datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_peak         <= 32'd0;
            r_frame_cnt    <= '0;
            r_srch         <= 32'd0;
            r_bit_idx      <= 5'd31;
            r_found        <= 1'b0;
            r_p            <= 5'd0;
            r_next         <= 5'd0;
            r_cur          <= 5'd0;
            r_coeff_update <= 1'b0;
            r_clip         <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_coeff_update <= 1'b0;
            r_clip         <= 1'b0;
            r_overrun      <= 1'b0;

            if (!cfg_auto) begin
                // Manual mode: discard window state and any pending value.
                r_peak      <= 32'd0;
                r_frame_cnt <= '0;
                r_next      <= r_cur;
                if (ms_in && (w_man != r_cur)) begin
                    r_cur          <= w_man;
                    r_coeff_update <= 1'b1;
                end
            end else begin
                // Accumulation runs every frame regardless of FSM state.
                if (ms_in) begin
                    if (w_win_close) begin
                        r_peak      <= 32'd0;
                        r_frame_cnt <= '0;
                        if (r_state == IDLE) begin
                            r_srch <= w_combined;
                        end else begin
                            r_overrun <= 1'b1;
                        end
                    end else begin
                        r_peak      <= w_combined;
                        r_frame_cnt <= r_frame_cnt + 1'b1;
                    end
                end

                case (r_state)
                    IDLE: begin
                        if (w_win_close) begin
                            r_bit_idx <= 5'd31;
                            r_found   <= 1'b0;
                            r_p       <= 5'd0;
                        end
                    end
                    SEARCH: begin
                        // Only the first (highest) set bit is recorded.
                        if (!r_found && r_srch[r_bit_idx]) begin
                            r_found <= 1'b1;
                            r_p     <= r_bit_idx;
                        end
                        r_bit_idx <= r_bit_idx - 5'd1;
                    end
                    DECIDE: begin
                        r_next <= w_next_coeff;
                        r_clip <= w_clip;
                    end
                    PEND: begin
                        if (ms_in) begin
                            r_cur          <= r_next;
                            r_coeff_update <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign scaled_coeff = {11'd0, r_cur};
    assign coeff_update = r_coeff_update;
    assign clip_det     = r_clip;
    assign overrun      = r_overrun;

endmodule
`default_nettype wire
